// File: rtl/branch_predictor_pkg.sv
// Shared defaults, update classification and counter init helper for the branch predictor.
package branch_predictor_pkg;

  localparam int BP_DEF_ENTRIES    = 16;
  localparam int BP_DEF_CTR_BITS   = 2;
  localparam int BP_DEF_PC_WIDTH   = 32;
  localparam int BP_DEF_STAT_WIDTH = 32;

  // What a resolved branch does to the table
  typedef enum logic [1:0] {
    UPD_NONE,
    UPD_TRAIN,
    UPD_ALLOC
  } upd_kind_e;

  // Weakly-taken value: only the counter MSB set
  function automatic int weak_taken_init(input int ctr_bits);
    return 1 << (ctr_bits - 1);
  endfunction

endpackage

// File: rtl/branch_predictor_sat_counter.sv
// Saturating up/down direction counter; returns the next value, never wraps.
module branch_predictor_sat_counter #(
  parameter int CTR_BITS = 2
) (
  input  logic [CTR_BITS-1:0] ctr_in,
  input  logic                inc,
  input  logic                dec,
  output logic [CTR_BITS-1:0] ctr_out
);

  localparam logic [CTR_BITS-1:0] CTR_MAX = '1;
  localparam logic [CTR_BITS-1:0] CTR_MIN = '0;

  // Step toward taken or not-taken, holding at the rails
  always_comb begin
    ctr_out = ctr_in;
    if (inc && (ctr_in != CTR_MAX)) begin
      ctr_out = ctr_in + CTR_BITS'(1);
    end else if (dec && (ctr_in != CTR_MIN)) begin
      ctr_out = ctr_in - CTR_BITS'(1);
    end
  end

endmodule

// File: rtl/branch_predictor.sv
// Direct-mapped BTB with per-entry saturating direction counters and branch statistics.
module branch_predictor
  import branch_predictor_pkg::*;
#(
  parameter int ENTRIES    = BP_DEF_ENTRIES,
  parameter int CTR_BITS   = BP_DEF_CTR_BITS,
  parameter int PC_WIDTH   = BP_DEF_PC_WIDTH,
  parameter int STAT_WIDTH = BP_DEF_STAT_WIDTH
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [PC_WIDTH-1:0]   if_pc,
  output logic                  pred_taken,
  output logic [PC_WIDTH-1:0]   pred_target,
  input  logic                  upd_valid,
  input  logic [PC_WIDTH-1:0]   upd_pc,
  input  logic                  upd_taken,
  input  logic [PC_WIDTH-1:0]   upd_target,
  input  logic                  upd_mispredict,
  output logic [STAT_WIDTH-1:0] stat_branches,
  output logic [STAT_WIDTH-1:0] stat_mispredicts
);

  localparam int IDX_BITS = $clog2(ENTRIES);
  localparam int TAG_BITS = PC_WIDTH - IDX_BITS - 2;
  localparam logic [CTR_BITS-1:0] CTR_WEAK_TAKEN = CTR_BITS'(weak_taken_init(CTR_BITS));

  logic                valid_q  [ENTRIES];
  logic                valid_d  [ENTRIES];
  logic [TAG_BITS-1:0] tag_q    [ENTRIES];
  logic [TAG_BITS-1:0] tag_d    [ENTRIES];
  logic [PC_WIDTH-1:0] target_q [ENTRIES];
  logic [PC_WIDTH-1:0] target_d [ENTRIES];
  logic [CTR_BITS-1:0] ctr_q    [ENTRIES];
  logic [CTR_BITS-1:0] ctr_d    [ENTRIES];

  logic [STAT_WIDTH-1:0] stat_branches_q;
  logic [STAT_WIDTH-1:0] stat_branches_d;
  logic [STAT_WIDTH-1:0] stat_mispredicts_q;
  logic [STAT_WIDTH-1:0] stat_mispredicts_d;

  logic [IDX_BITS-1:0] lk_idx;
  logic [TAG_BITS-1:0] lk_tag;
  logic                lk_hit;
  logic [IDX_BITS-1:0] up_idx;
  logic [TAG_BITS-1:0] up_tag;
  logic                up_hit;
  upd_kind_e           upd_kind;
  logic [CTR_BITS-1:0] ctr_next;
  logic                unused_pc_low;

  // Instruction addresses are word aligned, so the low two bits never select anything
  assign unused_pc_low = ^{if_pc[1:0], upd_pc[1:0]};

  assign lk_idx = if_pc[IDX_BITS+1:2];
  assign lk_tag = if_pc[PC_WIDTH-1:IDX_BITS+2];
  assign up_idx = upd_pc[IDX_BITS+1:2];
  assign up_tag = upd_pc[PC_WIDTH-1:IDX_BITS+2];

  // Fetch-side lookup reads registered state only, so a same-cycle update is not bypassed
  always_comb begin
    lk_hit      = valid_q[lk_idx] && (tag_q[lk_idx] == lk_tag);
    pred_taken  = lk_hit && ctr_q[lk_idx][CTR_BITS-1];
    pred_target = pred_taken ? target_q[lk_idx] : (if_pc + PC_WIDTH'(4));
  end

  // Decide whether the resolved branch trains an existing entry, allocates one, or is dropped
  always_comb begin
    up_hit   = valid_q[up_idx] && (tag_q[up_idx] == up_tag);
    upd_kind = UPD_NONE;
    if (upd_valid) begin
      if (up_hit) begin
        upd_kind = UPD_TRAIN;
      end else if (upd_taken) begin
        upd_kind = UPD_ALLOC;
      end
    end
  end

  branch_predictor_sat_counter #(
    .CTR_BITS (CTR_BITS)
  ) u_sat_counter (
    .ctr_in  (ctr_q[up_idx]),
    .inc     ((upd_kind == UPD_TRAIN) && upd_taken),
    .dec     ((upd_kind == UPD_TRAIN) && !upd_taken),
    .ctr_out (ctr_next)
  );

  // Next table contents and statistics; only the indexed entry can change
  always_comb begin
    valid_d  = valid_q;
    tag_d    = tag_q;
    target_d = target_q;
    ctr_d    = ctr_q;
    case (upd_kind)
      UPD_TRAIN: begin
        ctr_d[up_idx] = ctr_next;
        if (upd_taken) begin
          target_d[up_idx] = upd_target;
        end
      end
      UPD_ALLOC: begin
        valid_d[up_idx]  = 1'b1;
        tag_d[up_idx]    = up_tag;
        target_d[up_idx] = upd_target;
        ctr_d[up_idx]    = CTR_WEAK_TAKEN;
      end
      default: ;
    endcase
    stat_branches_d    = stat_branches_q + STAT_WIDTH'(upd_valid);
    stat_mispredicts_d = stat_mispredicts_q + STAT_WIDTH'(upd_valid & upd_mispredict);
  end

  // Table and counters; asynchronous clear wipes every entry at once
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      for (int i = 0; i < ENTRIES; i++) begin
        valid_q[i]  <= 1'b0;
        tag_q[i]    <= '0;
        target_q[i] <= '0;
        ctr_q[i]    <= '0;
      end
      stat_branches_q    <= '0;
      stat_mispredicts_q <= '0;
    end else begin
      valid_q            <= valid_d;
      tag_q              <= tag_d;
      target_q           <= target_d;
      ctr_q              <= ctr_d;
      stat_branches_q    <= stat_branches_d;
      stat_mispredicts_q <= stat_mispredicts_d;
    end
  end

  assign stat_branches    = stat_branches_q;
  assign stat_mispredicts = stat_mispredicts_q;

endmodule

// File: tb/tb_branch_predictor.sv
// Scoreboard bench for branch_predictor: a behavioural BTB model predicts each cycle's outputs.
module tb_branch_predictor;

  localparam int ENTRIES    = 16;
  localparam int CTR_BITS   = 2;
  localparam int PC_WIDTH   = 32;
  localparam int STAT_WIDTH = 32;

  logic        clk = 1'b0;
  logic        reset = 1'b0;
  logic [31:0] if_pc = '0;
  logic        pred_taken;
  logic [31:0] pred_target;
  logic        upd_valid = 1'b0;
  logic [31:0] upd_pc = '0;
  logic        upd_taken = 1'b0;
  logic [31:0] upd_target = '0;
  logic        upd_mispredict = 1'b0;
  logic [31:0] stat_branches;
  logic [31:0] stat_mispredicts;

  int checkCount = 0;
  int errorCount = 0;

  typedef struct packed {
    logic        taken;
    logic [31:0] target;
    logic [31:0] branches;
    logic [31:0] mispredicts;
  } exp_t;

  exp_t  expQ[$];
  string tagQ[$];

  // Reference model state
  logic        mValid  [ENTRIES];
  logic [25:0] mTag    [ENTRIES];
  logic [31:0] mTarget [ENTRIES];
  int          mCtr    [ENTRIES];
  logic [31:0] mBranches;
  logic [31:0] mMispredicts;

  branch_predictor #(
    .ENTRIES    (ENTRIES),
    .CTR_BITS   (CTR_BITS),
    .PC_WIDTH   (PC_WIDTH),
    .STAT_WIDTH (STAT_WIDTH)
  ) dut (
    .clk              (clk),
    .reset            (reset),
    .if_pc            (if_pc),
    .pred_taken       (pred_taken),
    .pred_target      (pred_target),
    .upd_valid        (upd_valid),
    .upd_pc           (upd_pc),
    .upd_taken        (upd_taken),
    .upd_target       (upd_target),
    .upd_mispredict   (upd_mispredict),
    .stat_branches    (stat_branches),
    .stat_mispredicts (stat_mispredicts)
  );

  // Free-running 10-unit clock
  always #5 clk = ~clk;

  task automatic checkOutput(input string tag, input logic [63:0] observed, input logic [63:0] expected);
    checkCount++;
    if (observed !== expected) begin
      errorCount++;
      $display("[TB] FAIL %s: got 0x%0h, expected 0x%0h", tag, observed, expected);
    end
  endtask

  function automatic void modelClear();
    for (int i = 0; i < ENTRIES; i++) begin
      mValid[i]  = 1'b0;
      mTag[i]    = '0;
      mTarget[i] = '0;
      mCtr[i]    = 0;
    end
    mBranches    = '0;
    mMispredicts = '0;
  endfunction

  function automatic exp_t modelLookup(input logic [31:0] pc);
    exp_t r;
    int   idx;
    logic hit;
    idx           = int'(pc[5:2]);
    hit           = mValid[idx] && (mTag[idx] == pc[31:6]);
    r.taken       = hit && (mCtr[idx] >= 2);
    r.target      = r.taken ? mTarget[idx] : pc + 32'd4;
    r.branches    = mBranches;
    r.mispredicts = mMispredicts;
    return r;
  endfunction

  function automatic void modelUpdate(input logic [31:0] pc, input logic taken,
                                      input logic [31:0] tgt, input logic mis);
    int   idx;
    logic hit;
    idx = int'(pc[5:2]);
    hit = mValid[idx] && (mTag[idx] == pc[31:6]);
    mBranches = mBranches + 32'd1;
    if (mis) mMispredicts = mMispredicts + 32'd1;
    if (hit) begin
      if (taken) begin
        if (mCtr[idx] < 3) mCtr[idx] = mCtr[idx] + 1;
        mTarget[idx] = tgt;
      end else if (mCtr[idx] > 0) begin
        mCtr[idx] = mCtr[idx] - 1;
      end
    end else if (taken) begin
      mValid[idx]  = 1'b1;
      mTag[idx]    = pc[31:6];
      mTarget[idx] = tgt;
      mCtr[idx]    = 2;
    end
  endfunction

  // One cycle: drive, queue expectation, compare at negedge, advance model at posedge
  task automatic applyStimulus(input string tag, input logic [31:0] pc, input logic uv,
                               input logic [31:0] upc, input logic ut,
                               input logic [31:0] utgt, input logic umis);
    exp_t  e;
    string t;
    if_pc          = pc;
    upd_valid      = uv;
    upd_pc         = upc;
    upd_taken      = ut;
    upd_target     = utgt;
    upd_mispredict = umis;
    expQ.push_back(modelLookup(pc));
    tagQ.push_back(tag);
    @(negedge clk);
    if (expQ.size() == 0) begin
      checkOutput("scoreboard_empty", 64'd0, 64'd1);
    end else begin
      e = expQ.pop_front();
      t = tagQ.pop_front();
      checkOutput({t, "_taken"}, 64'(pred_taken), 64'(e.taken));
      checkOutput({t, "_target"}, 64'(pred_target), 64'(e.target));
      checkOutput({t, "_branches"}, 64'(stat_branches), 64'(e.branches));
      checkOutput({t, "_mispredicts"}, 64'(stat_mispredicts), 64'(e.mispredicts));
    end
    @(posedge clk);
    if (uv) modelUpdate(upc, ut, utgt, umis);
    #1;
  endtask

  task automatic idleInputs();
    upd_valid      = 1'b0;
    upd_taken      = 1'b0;
    upd_mispredict = 1'b0;
  endtask

  // Assert reset between edges and check that it takes effect without a clock
  task automatic midCycleReset(input string tag);
    idleInputs();
    if_pc = 32'h100;
    reset = 1'b0;
    #1;
    modelClear();
    checkOutput({tag, "_branches"}, 64'(stat_branches), 64'd0);
    checkOutput({tag, "_mispredicts"}, 64'(stat_mispredicts), 64'd0);
    checkOutput({tag, "_taken"}, 64'(pred_taken), 64'd0);
    checkOutput({tag, "_target"}, 64'(pred_target), 64'h104);
    @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;
  endtask

  logic [31:0] pcPool [5];

  initial begin
    pcPool[0] = 32'h100; pcPool[1] = 32'h140; pcPool[2] = 32'h104;
    pcPool[3] = 32'h200; pcPool[4] = 32'h3C8;
    modelClear();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    reset = 1'b1;
    @(posedge clk);
    #1;

    applyStimulus("reset_lookup", 32'h100, 0, 0, 0, 0, 0);
    applyStimulus("alloc_same_cycle", 32'h100, 1, 32'h100, 1, 32'h40, 0);
    applyStimulus("hit_ctr2", 32'h100, 1, 32'h100, 0, 32'h0, 1);
    applyStimulus("ctr1_nt", 32'h100, 1, 32'h100, 0, 32'h0, 0);
    applyStimulus("ctr0_nt", 32'h100, 1, 32'h100, 0, 32'h0, 0);
    for (int i = 0; i < 4; i++) begin
      applyStimulus("train_up", 32'h100, 1, 32'h100, 1, 32'h40, 0);
    end
    applyStimulus("sat3", 32'h100, 1, 32'h100, 0, 32'h0, 0);
    applyStimulus("sat_back2", 32'h100, 0, 0, 0, 0, 0);
    applyStimulus("alias_alloc", 32'h140, 1, 32'h140, 1, 32'h80, 1);
    applyStimulus("alias_old_miss", 32'h100, 0, 0, 0, 0, 0);
    applyStimulus("alias_new_hit", 32'h140, 0, 0, 0, 0, 0);
    applyStimulus("nobypass_200", 32'h200, 1, 32'h200, 1, 32'h300, 0);
    applyStimulus("after_200", 32'h200, 1, 32'h200, 1, 32'h480, 0);
    applyStimulus("retarget_200", 32'h200, 1, 32'h604, 0, 32'h0, 0);
    applyStimulus("miss_nt_noalloc", 32'h604, 1, 32'h0, 0, 32'h0, 1);
    applyStimulus("mis_no_valid", 32'hFFFF_FFFC, 0, 32'h200, 1, 32'h10, 1);
    applyStimulus("wrap_pc", 32'hFFFF_FFFC, 0, 0, 0, 0, 0);

    for (int i = 0; i < 40; i++) begin
      applyStimulus("random", pcPool[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                    pcPool[$urandom_range(0, 4)], 1'($urandom_range(0, 1)),
                    {$urandom_range(0, 255), 2'b00}, 1'($urandom_range(0, 1)));
    end

    midCycleReset("reset_a");
    applyStimulus("post_reset_miss_a", 32'h100, 1, 32'h100, 1, 32'h40, 1);
    applyStimulus("stats_b", 32'h100, 1, 32'h140, 0, 32'h0, 0);
    applyStimulus("stats_c", 32'h100, 1, 32'h100, 1, 32'h44, 1);
    applyStimulus("stats_d", 32'h100, 1, 32'h108, 1, 32'h50, 0);
    applyStimulus("stats_e", 32'h100, 1, 32'h100, 0, 32'h0, 0);
    idleInputs();
    @(negedge clk);
    checkOutput("five_branches", 64'(stat_branches), 64'd5);
    checkOutput("two_mispredicts", 64'(stat_mispredicts), 64'd2);
    @(posedge clk);
    #2;
    midCycleReset("reset_b");
    applyStimulus("post_reset_miss_b", 32'h100, 0, 0, 0, 0, 0);
    applyStimulus("post_reset_first_upd", 32'h108, 1, 32'h108, 1, 32'h70, 0);
    applyStimulus("post_reset_hit", 32'h108, 0, 0, 0, 0, 0);

    checkOutput("scoreboard_drained", 64'(expQ.size()), 64'd0);
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $finish;
  end

  // Hard stop if the stimulus ever stalls
  initial begin
    #200000;
    errorCount++;
    $display("[TB] FAIL watchdog: got timeout, expected completion");
    $display("Simulation finished: %0d checks, %0d errors", checkCount, errorCount);
    $fatal(1, "[TB] watchdog expired");
  end

endmodule
